// File: rtl/imem_loader.sv
// imem_loader: receives a framed byte stream and writes the program image it
// carries into instruction memory. The CPU is held in reset while a load runs.
// Frame layout: N[7:0], N[15:8], then 4*N little-endian data bytes, then one
// checksum byte equal to the XOR of all data bytes.
module imem_loader #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              res,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_res,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN0,
    S_LEN1,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  // Largest word count that fits in the memory. Any larger N is rejected.
  localparam logic [31:0] MAX_WORDS = 32'd1 << ADDR_W;

  state_t            r_state;
  state_t            w_next_state;

  logic [7:0]        r_len_lo;      // N[7:0], held until the high byte arrives
  logic [15:0]       r_words_left;  // data words still expected in this frame
  logic [ADDR_W-1:0] r_idx;         // address of the word being assembled
  logic [1:0]        r_byte_sel;    // byte position inside the current word
  logic [23:0]       r_word;        // lower three bytes of the current word
  logic [7:0]        r_csum;        // running XOR of the data bytes
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic              r_cpu_res;
  logic              r_done;
  logic              r_err;

  logic              w_rx_ready;
  logic              w_hs;
  logic [15:0]       w_len;
  logic              w_too_long;
  logic              w_start_load;

  // The loader takes bytes in the four frame-receiving states only.
  assign w_rx_ready   = (r_state == S_LEN0) || (r_state == S_LEN1) ||
                        (r_state == S_DATA) || (r_state == S_CSUM);
  assign w_hs         = rx_valid && w_rx_ready;
  assign w_len        = {rx_data, r_len_lo};
  assign w_too_long   = {16'd0, w_len} > MAX_WORDS;
  // A start pulse is honoured only when no load is running.
  assign w_start_load = start &&
                        ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR));

  // State register. Reset returns to IDLE from any state and aborts a load.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so that every
    // register samples values from before the clock edge, regardless of
    // the order in which always blocks are evaluated.
    if (res) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic. It uses rx_valid directly, because rx_ready is already
  // implied by the state being tested.
  always_comb begin
    // NOTE: the default assignment first means every path assigns
    // w_next_state, so no latch is inferred.
    w_next_state = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) w_next_state = S_LEN0;
      end
      S_LEN0: begin
        if (rx_valid) w_next_state = S_LEN1;
      end
      S_LEN1: begin
        if (rx_valid) begin
          if (w_too_long)          w_next_state = S_ERR;
          else if (w_len == 16'd0) w_next_state = S_CSUM;
          else                     w_next_state = S_DATA;
        end
      end
      S_DATA: begin
        if (rx_valid && (r_byte_sel == 2'd3) && (r_words_left == 16'd1)) begin
          w_next_state = S_CSUM;
        end
      end
      S_CSUM: begin
        if (rx_valid) w_next_state = (rx_data == r_csum) ? S_DONE : S_ERR;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Datapath: length capture, word assembly, checksum, write strobe, status flags.
  always_ff @(posedge clk) begin
    if (res) begin
      r_len_lo     <= '0;
      r_words_left <= '0;
      r_idx        <= '0;
      r_byte_sel   <= '0;
      r_word       <= '0;
      r_csum       <= '0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_cpu_res    <= 1'b1;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_we      <= 1'b0;
      // The CPU is held during a load and after a failed load. It is released
      // in IDLE, so a preloaded image runs, and in DONE.
      r_cpu_res <= (r_state != S_IDLE) && (r_state != S_DONE);

      if (w_start_load) begin
        r_idx        <= '0;
        r_byte_sel   <= '0;
        r_csum       <= '0;
        r_words_left <= '0;
        r_done       <= 1'b0;
        r_err        <= 1'b0;
      end

      if (w_hs) begin
        case (r_state)
          S_LEN0: r_len_lo <= rx_data;
          S_LEN1: begin
            r_words_left <= w_len;
            if (w_too_long) r_err <= 1'b1;
          end
          S_DATA: begin
            r_csum     <= r_csum ^ rx_data;
            r_byte_sel <= r_byte_sel + 2'd1;
            case (r_byte_sel)
              2'd0: r_word[7:0]   <= rx_data;
              2'd1: r_word[15:8]  <= rx_data;
              2'd2: r_word[23:16] <= rx_data;
              default: begin
                // The last byte goes straight into the write data, so the
                // strobe comes out one cycle after this handshake.
                r_we         <= 1'b1;
                r_addr       <= r_idx;
                r_wdata      <= {rx_data, r_word};
                r_idx        <= r_idx + 1'b1;
                r_words_left <= r_words_left - 16'd1;
              end
            endcase
          end
          S_CSUM: begin
            if (rx_data == r_csum) r_done <= 1'b1;
            else                   r_err  <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign rx_ready   = w_rx_ready;
  assign busy       = w_rx_ready;
  assign imem_we    = r_we;
  assign imem_addr  = r_addr;
  assign imem_wdata = r_wdata;
  assign cpu_res    = r_cpu_res;
  assign done       = r_done;
  assign err        = r_err;

endmodule

// File: tb/tb_imem_loader.sv
// Directed testbench for imem_loader. Inputs change on the falling edge and
// outputs are sampled on the falling edge. Expected values are hand-computed.
module tb_imem_loader;

  localparam int ADDR_W = 12;

  logic              clk = 1'b0;
  logic              res;
  logic              start;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_res;
  logic              busy;
  logic              done;
  logic              err;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .res        (res),
    .start      (start),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_res    (cpu_res),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Log every memory write seen on the write port.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wr_addr_q.push_back(32'(imem_addr));
      wr_data_q.push_back(imem_wdata);
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Present one byte, waiting for rx_ready, and return at the falling edge
  // after the handshake. A stalled loader counts as a failure.
  task automatic send_byte(input logic [7:0] b);
    int guard = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && guard < 20) begin
      step();
      guard++;
    end
    if (!rx_ready) check("rx_ready_timeout", 32'(rx_ready), 32'd1);
    step();
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] bytes[$]);
    foreach (bytes[i]) send_byte(bytes[i]);
  endtask

  task automatic clear_log();
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] frame[$];
    logic [7:0] f3[$];
    logic [31:0] exp3[3];

    res = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;

    // Reset state, then no start.
    repeat (3) step();
    check("rst_cpu_res", 32'(cpu_res), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rx_ready", 32'(rx_ready), 32'd0);
    check("rst_done_err", {30'd0, done, err}, 32'd0);
    check("rst_addr", 32'(imem_addr), 32'd0);
    check("rst_wdata", imem_wdata, 32'd0);
    res = 1'b0;
    #1 check("cpu_res_hold_after_res", 32'(cpu_res), 32'd1);
    step();
    check("cpu_res_release_idle", 32'(cpu_res), 32'd0);
    repeat (4) step();
    #1 check("idle_no_writes", 32'(wr_addr_q.size()), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);

    // Good single-word frame.
    pulse_start();
    check("load_busy", 32'(busy), 32'd1);
    frame = '{8'h01, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h06};
    send_frame(frame);
    check("good_done", 32'(done), 32'd1);
    check("good_err", 32'(err), 32'd0);
    check("good_cpu_res_at_done", 32'(cpu_res), 32'd1);
    step();
    check("good_cpu_res_released", 32'(cpu_res), 32'd0);
    check("good_busy", 32'(busy), 32'd0);
    #1 check("good_nwrites", 32'(wr_addr_q.size()), 32'd1);
    if (wr_addr_q.size() == 1) begin
      check("good_addr", wr_addr_q[0], 32'd0);
      check("good_wdata", wr_data_q[0], 32'h0010_0513);
    end

    // Same frame with a bad checksum.
    clear_log();
    pulse_start();
    frame = '{8'h01, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h07};
    send_frame(frame);
    check("bad_err", 32'(err), 32'd1);
    check("bad_done", 32'(done), 32'd0);
    step();
    step();
    check("bad_cpu_res_held", 32'(cpu_res), 32'd1);
    #1 check("bad_nwrites", 32'(wr_addr_q.size()), 32'd1);
    if (wr_data_q.size() == 1) check("bad_wdata", wr_data_q[0], 32'h0010_0513);
    pulse_start();
    check("restart_clears_err", 32'(err), 32'd0);

    // Zero-length frame, loaded straight after the restart.
    clear_log();
    frame = '{8'h00, 8'h00, 8'h00};
    send_frame(frame);
    check("zero_done", 32'(done), 32'd1);
    check("zero_err", 32'(err), 32'd0);
    #1 check("zero_nwrites", 32'(wr_addr_q.size()), 32'd0);

    // N = 4097 exceeds the memory and fails right after the second length byte.
    pulse_start();
    frame = '{8'h01, 8'h10};
    send_frame(frame);
    check("ovf_err", 32'(err), 32'd1);
    check("ovf_busy", 32'(busy), 32'd0);
    check("ovf_rx_ready", 32'(rx_ready), 32'd0);

    // N = 4096 fits exactly, so the loader enters the data phase. Reset aborts it.
    pulse_start();
    frame = '{8'h00, 8'h10};
    send_frame(frame);
    check("max_busy", 32'(busy), 32'd1);
    check("max_err", 32'(err), 32'd0);
    res = 1'b1;
    step();
    check("max_abort_busy", 32'(busy), 32'd0);
    check("max_abort_cpu_res", 32'(cpu_res), 32'd1);
    res = 1'b0;
    step();
    step();

    // Three words with random gaps and start pulses during the load.
    clear_log();
    exp3 = '{32'hDEAD_BEEF, 32'h1234_5678, 32'hA5A5_005A};
    f3 = '{8'h03, 8'h00,
           8'hEF, 8'hBE, 8'hAD, 8'hDE,
           8'h78, 8'h56, 8'h34, 8'h12,
           8'h5A, 8'h00, 8'hA5, 8'hA5,
           8'h70};
    pulse_start();
    foreach (f3[i]) begin
      int gaps = int'($urandom_range(0, 2)) + (((i == 3) || (i == 9)) ? 1 : 0);
      for (int g = 0; g < gaps; g++) begin
        rx_valid = 1'b0;
        start = ((g == 0) && ((i == 3) || (i == 9)));
        step();
        start = 1'b0;
      end
      send_byte(f3[i]);
    end
    check("multi_done", 32'(done), 32'd1);
    check("multi_err", 32'(err), 32'd0);
    step();
    #1 check("multi_nwrites", 32'(wr_addr_q.size()), 32'd3);
    if (wr_addr_q.size() == 3) begin
      for (int k = 0; k < 3; k++) begin
        check($sformatf("multi_addr%0d", k), wr_addr_q[k], 32'(k));
        check($sformatf("multi_wdata%0d", k), wr_data_q[k], exp3[k]);
      end
    end

    // Reset after six data bytes, then a fresh load.
    clear_log();
    pulse_start();
    frame = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    send_frame(frame);
    res = 1'b1;
    step();
    check("abort_we", 32'(imem_we), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_cpu_res", 32'(cpu_res), 32'd1);
    step();
    res = 1'b0;
    repeat (3) step();
    #1 check("abort_nwrites", 32'(wr_addr_q.size()), 32'd1);
    if (wr_data_q.size() == 1) check("abort_first_word", wr_data_q[0], 32'h4433_2211);
    check("abort_idle_done", 32'(done), 32'd0);

    clear_log();
    pulse_start();
    frame = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08};
    send_frame(frame);
    check("reload_done", 32'(done), 32'd1);
    step();
    #1 check("reload_nwrites", 32'(wr_addr_q.size()), 32'd1);
    if (wr_addr_q.size() == 1) begin
      check("reload_addr", wr_addr_q[0], 32'd0);
      check("reload_wdata", wr_data_q[0], 32'h1234_5678);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
